// File: rtl/uart_pkg.sv
// Shared constants, status-word bit positions and receiver state type for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int VALID_BIT      = 23;
  localparam int OVR_BIT        = 22;
  localparam int FERR_BIT       = 21;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; a push while full is accepted only if a pop retires the head in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a Wishbone status/pop word. Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry
// receive FIFO; otherwise a single holding register buffers one byte.
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 862,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic          meta_q, rxs_q;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          push, frame_bad, pop, full, valid, wr_clr, overrun_evt;
  logic [UART_DATA_BITS-1:0] head;
  logic          unused_ok;

  // Receiver FSM; every transition clears the bit-timing counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          state_d   = IDLE;
          push      = rxs_q;
          frame_bad = ~rxs_q;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop         = cyc_i & stb_i & ~we_i & valid;
  assign wr_clr      = cyc_i & stb_i & we_i;
  assign overrun_evt = push & full & ~pop;

  // Sticky flags: a set event in the same cycle overrides a software clear.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_clr && dat_i[OVR_BIT])  ovr_d  = 1'b0;
    if (wr_clr && dat_i[FERR_BIT]) ferr_d = 1'b0;
    if (overrun_evt) ovr_d  = 1'b1;
    if (frame_bad)   ferr_d = 1'b1;
  end

`ifdef UART_RX_FIFO_EN
  logic empty;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign valid     = ~empty;
  assign unused_ok = ^{dat_i[31:23], dat_i[20:0]};
`else
  logic hold_valid_q, hold_valid_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (pop) hold_valid_d = 1'b0;
    if (push && (!hold_valid_q || pop)) begin
      hold_d       = shift_q;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign full      = hold_valid_q;
  assign valid     = hold_valid_q;
  assign head      = hold_q;
  assign unused_ok = ^{dat_i[31:23], dat_i[20:0], FIFO_DEPTH[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      meta_q  <= rxd;
      rxs_q   <= meta_q;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    dat_o           = '0;
    dat_o[31:24]    = valid ? head : '0;
    dat_o[VALID_BIT] = valid;
    dat_o[OVR_BIT]  = ovr_q;
    dat_o[FERR_BIT] = ferr_q;
  end

  assign ack_o = stb_i;
  assign irq_o = valid;
endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx at 16 clocks per bit; buffer depth follows UART_RX_FIFO_EN.
module tb_wb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic        ack_o, irq_o;
  logic [31:0] dat_o;

  int checks   = 0;
  int failures = 0;

  wb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .rxd  (rxd),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .we_i (we_i),
    .dat_i(dat_i),
    .ack_o(ack_o),
    .dat_o(dat_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_read(input string tag, input logic [31:0] exp);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    #1;
    chk(tag, dat_o, exp);
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = d;
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
  endtask

  // mode 0: plain frame; mode 1: check valid rises exactly one clock after the stop sample;
  // mode 2: issue a pop during the stop-sample cycle, expecting exp on dat_o.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode,
                            input logic [31:0] exp);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    for (int j = 1; j <= CPB; j++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && j == 10) chk("latency_before", dat_o, 32'h0);
      if (mode == 1 && j == 11) chk("latency_after", dat_o, exp);
      if (mode == 2 && j == 10) begin
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        #1;
        chk("pop_at_push_head", dat_o, exp);
      end
      if (mode == 2 && j == 11) begin
        cyc_i = 1'b0; stb_i = 1'b0;
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    // Reset values, including ack following stb during reset
    tick(3);
    chk("reset_dat_o", dat_o, 32'h0);
    chk("reset_irq", {31'b0, irq_o}, 32'h0);
    chk("reset_ack_low", {31'b0, ack_o}, 32'h0);
    stb_i = 1'b1;
    #1;
    chk("reset_ack_follows_stb", {31'b0, ack_o}, 32'h1);
    stb_i = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);

    // Frame 0xA5 with exact latency
    send_frame(8'hA5, 1'b1, 1, 32'hA580_0000);
    chk("a5_irq", {31'b0, irq_o}, 32'h1);
    tick(4);
    wb_read("a5_read", 32'hA580_0000);
    wb_read("a5_empty_read", 32'h0);
    chk("a5_irq_after_pop", {31'b0, irq_o}, 32'h0);

    // One-clock glitch on idle line
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(3);
    chk("glitch_in_start", {30'b0, dut.state_q}, {30'b0, START});
    tick(20);
    chk("glitch_state_idle", {30'b0, dut.state_q}, {30'b0, IDLE});
    chk("glitch_dat_o", dat_o, 32'h0);

    // Stop bit low: frame error, byte discarded, then clear
    send_frame(8'h5A, 1'b0, 0, 32'h0);
    tick(30);
    chk("ferr_dat_o", dat_o, 32'h0020_0000);
    chk("ferr_irq", {31'b0, irq_o}, 32'h0);
    wb_write(32'h0060_0000);
    chk("ferr_cleared", dat_o, 32'h0);

    // Overrun: one more frame than the buffer holds
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(8'h11 * (i + 1)), 1'b1, 0, 32'h0);
      tick(4);
    end
    for (int i = 0; i < DEPTH; i++)
      wb_read("ovr_read", {8'(8'h11 * (i + 1)), 24'hC0_0000});
    wb_read("ovr_empty_read", 32'h0040_0000);
    wb_write(32'h0040_0000);
    chk("ovr_cleared", dat_o, 32'h0);

    // Pop coinciding with push on a full buffer
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(8'h40 + i), 1'b1, 0, 32'h0);
      tick(4);
    end
    send_frame(8'(8'h40 + DEPTH), 1'b1, 2, 32'h4080_0000);
    tick(4);
    for (int i = 1; i <= DEPTH; i++)
      wb_read("pop_push_read", {8'(8'h40 + i), 24'h80_0000});
    wb_read("pop_push_empty", 32'h0);

    // Reset mid-DATA with a byte already buffered
    send_frame(8'h77, 1'b1, 0, 32'h0);
    tick(4);
    chk("pre_reset_buffered", dat_o, 32'h7780_0000);
    rxd = 1'b0;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
    rxd = 1'b0;
    tick(CPB / 2);
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    chk("midframe_rst_dat_o", dat_o, 32'h0);
    chk("midframe_rst_irq", {31'b0, irq_o}, 32'h0);
    chk("midframe_rst_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    tick(3);
    rst = 1'b0;
    tick(5);
    send_frame(8'h3C, 1'b1, 0, 32'h0);
    tick(4);
    wb_read("post_reset_3c", 32'h3C80_0000);
    wb_read("post_reset_empty", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
